// File: rtl/wqe_pkg.sv
// Shared definitions for the WQE dispatcher: WQE field layout, DCS register
// offsets and FSM state encoding.
package wqe_pkg;

    localparam int WQE_W     = 116;

    localparam int OPCODE_HI = 115;
    localparam int OPCODE_LO = 111;
    localparam int DNUM_HI   = 110;
    localparam int DNUM_LO   = 108;
    localparam int TID_HI    = 107;
    localparam int TID_LO    = 100;
    localparam int LEN0_LO   = 91;
    localparam int LEN_W     = 9;
    localparam int TADDR_HI  = 63;
    localparam int NUM_LEN   = 4;

    localparam logic [7:0] OFF_ADDR_LO = 8'h00;
    localparam logic [7:0] OFF_ADDR_HI = 8'h04;
    localparam logic [7:0] OFF_LEN     = 8'h08;
    localparam logic [7:0] OFF_CTRL    = 8'h18;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP     = 3'd1,
        LOAD    = 3'd2,
        ADDR_LO = 3'd3,
        ADDR_HI = 3'd4,
        LEN     = 3'd5,
        CTRL    = 3'd6,
        DONE    = 3'd7
    } state_t;

endpackage

// File: rtl/wqe_dispatcher_if.sv
// Work-FIFO pop port and AVMM write master bundled for the WQE dispatcher.
interface wqe_dispatcher_if;
    import wqe_pkg::*;

    logic             wqeEmpty;
    logic             wqePop;
    logic [WQE_W-1:0] wqeData;
    logic             dcsChipSelect;
    logic             dcsWrite;
    logic [7:0]       dcsAddress;
    logic [31:0]      dcsWriteData;
    logic [3:0]       dcsByteEnable;
    logic             dcsWaitRequest;

    modport master (
        input  wqeEmpty, wqeData, dcsWaitRequest,
        output wqePop, dcsChipSelect, dcsWrite, dcsAddress, dcsWriteData, dcsByteEnable
    );

    modport slave (
        output wqeEmpty, wqeData, dcsWaitRequest,
        input  wqePop, dcsChipSelect, dcsWrite, dcsAddress, dcsWriteData, dcsByteEnable
    );

endinterface

// File: rtl/wqe_dispatcher.sv
// Pops WQEs from the work FIFO and replays them as AVMM register writes,
// doorbell last. Optional counters under `WQE_DISPATCH_STATS_EN.
module wqe_dispatcher
    import wqe_pkg::*;
#(
    parameter logic [7:0] DCS_BASE = 8'h00,
    parameter int         MAX_SEG  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    wqe_dispatcher_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic [7:0]        doneTid,
    output logic              dropErr
`ifdef WQE_DISPATCH_STATS_EN
    ,
    output logic [15:0]       statDispatched,
    output logic [15:0]       statDropped
`endif
);

    localparam logic [2:0] MAX_SEG_N = 3'(MAX_SEG);

    state_t      state, nextState;
    logic [1:0]  segCnt, segNext;
    logic [4:0]  opcodeReg;
    logic [2:0]  dataNumReg;
    logic [7:0]  tidReg;
    logic [8:0]  lenReg [NUM_LEN];
    logic [63:0] tableAddrReg;

    logic [2:0]  rawNum;
    logic [2:0]  clampedNum;
    logic        dropNow;
    logic        ctrlAccept;
    logic        cs;
    logic [7:0]  addr;
    logic [31:0] wdata;

    assign rawNum     = bus.wqeData[DNUM_HI:DNUM_LO];
    assign clampedNum = (rawNum > MAX_SEG_N) ? MAX_SEG_N : rawNum;
    assign dropNow    = (state == LOAD) && (rawNum == 3'd0);
    assign ctrlAccept = (state == CTRL) && !bus.dcsWaitRequest;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            segCnt  <= 2'd0;
            doneTid <= 8'd0;
            dropErr <= 1'b0;
        end else begin
            state   <= nextState;
            segCnt  <= segNext;
            dropErr <= dropNow;
            if (dropNow)
                doneTid <= bus.wqeData[TID_HI:TID_LO];
            else if (ctrlAccept)
                doneTid <= tidReg;
        end
    end

    // WQE payload only needs capturing; it is never observed outside write states.
    always_ff @(posedge clock) begin
        if (state == LOAD) begin
            opcodeReg    <= bus.wqeData[OPCODE_HI:OPCODE_LO];
            dataNumReg   <= clampedNum;
            tidReg       <= bus.wqeData[TID_HI:TID_LO];
            tableAddrReg <= bus.wqeData[TADDR_HI:0];
            for (int k = 0; k < NUM_LEN; k++)
                lenReg[k] <= bus.wqeData[LEN0_LO - LEN_W*k +: LEN_W];
        end
    end

    always_comb begin
        nextState = state;
        segNext   = segCnt;
        cs        = 1'b0;
        addr      = 8'd0;
        wdata     = 32'd0;
        case (state)
            IDLE:    if (enable && !bus.wqeEmpty) nextState = POP;
            POP:     nextState = LOAD;
            LOAD:    nextState = (rawNum == 3'd0) ? IDLE : ADDR_LO;
            ADDR_LO: begin
                cs    = 1'b1;
                addr  = DCS_BASE + OFF_ADDR_LO;
                wdata = tableAddrReg[31:0];
                if (!bus.dcsWaitRequest) nextState = ADDR_HI;
            end
            ADDR_HI: begin
                cs    = 1'b1;
                addr  = DCS_BASE + OFF_ADDR_HI;
                wdata = tableAddrReg[63:32];
                if (!bus.dcsWaitRequest) begin
                    nextState = LEN;
                    segNext   = 2'd0;
                end
            end
            LEN: begin
                cs    = 1'b1;
                addr  = DCS_BASE + OFF_LEN + {4'd0, segCnt, 2'b00};
                wdata = {23'd0, lenReg[segCnt]};
                if (!bus.dcsWaitRequest) begin
                    if ({1'b0, segCnt} == dataNumReg - 3'd1) begin
                        nextState = CTRL;
                        segNext   = 2'd0;
                    end else begin
                        segNext   = segCnt + 2'd1;
                    end
                end
            end
            CTRL: begin
                cs    = 1'b1;
                addr  = DCS_BASE + OFF_CTRL;
                wdata = {opcodeReg, dataNumReg, tidReg, 16'd0};
                if (!bus.dcsWaitRequest) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign busy              = (state != IDLE);
    assign done              = (state == DONE);
    assign bus.wqePop        = (state == POP);
    assign bus.dcsChipSelect = cs;
    assign bus.dcsWrite      = cs;
    assign bus.dcsAddress    = addr;
    assign bus.dcsWriteData  = wdata;
    assign bus.dcsByteEnable = 4'hf;

`ifdef WQE_DISPATCH_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            statDispatched <= 16'd0;
            statDropped    <= 16'd0;
        end else begin
            if (done)    statDispatched <= statDispatched + 16'd1;
            if (dropErr) statDropped    <= statDropped + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wqe_dispatcher.sv
// Scoreboard bench for wqe_dispatcher: FIFO/AVMM models, directed cases and
// randomized WQEs checked against a queue-based reference model.
module tb_wqe_dispatcher;
    import wqe_pkg::*;

    localparam logic [7:0] BASE = 8'h00;
    localparam int         MAXS = 4;

    typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
    typedef struct { bit drop; logic [7:0] tid; } ev_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       busy, done, dropErr;
    logic [7:0] doneTid;
`ifdef WQE_DISPATCH_STATS_EN
    logic [15:0] statDispatched, statDropped;
`endif

    wqe_dispatcher_if bus ();

    wqe_dispatcher #(.DCS_BASE(BASE), .MAX_SEG(MAXS)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .doneTid (doneTid),
        .dropErr (dropErr)
`ifdef WQE_DISPATCH_STATS_EN
        ,
        .statDispatched (statDispatched),
        .statDropped    (statDropped)
`endif
    );

    always #5 clock = ~clock;

    wr_t              expWr [$];
    ev_t              expEv [$];
    logic [WQE_W-1:0] fifo  [$];
    int vectors = 0;
    int errors  = 0;
    int acceptCount = 0;
    int stallCount  = 0;
    bit randomStall   = 0;
    bit stallDirected = 0;
    int stallBudget   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a WQE becomes a list of (address, data) writes and one completion.
    task automatic issue(input logic [4:0] op, input logic [2:0] n, input logic [7:0] tid,
                         input logic [8:0] lens [4], input logic [63:0] ta);
        int segs;
        fifo.push_back({op, n, tid, lens[0], lens[1], lens[2], lens[3], ta});
        if (n == 3'd0) begin
            expEv.push_back('{drop: 1'b1, tid: tid});
        end else begin
            segs = (int'(n) > MAXS) ? MAXS : int'(n);
            expWr.push_back('{addr: BASE + 8'h00, data: ta[31:0]});
            expWr.push_back('{addr: BASE + 8'h04, data: ta[63:32]});
            for (int k = 0; k < segs; k++)
                expWr.push_back('{addr: BASE + 8'(8 + 4*k), data: {23'd0, lens[k]}});
            expWr.push_back('{addr: BASE + 8'h18, data: {op, 3'(segs), tid, 16'd0}});
            expEv.push_back('{drop: 1'b0, tid: tid});
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expWr.size() != 0 || expEv.size() != 0 || fifo.size() != 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        #2;
        check("drain_left", 64'(expWr.size() + expEv.size() + fifo.size()), 64'd0);
    endtask

    // Work FIFO model
    initial begin
        bus.wqeEmpty = 1'b1;
        bus.wqeData  = '0;
        forever begin
            @(negedge clock);
            if (reset && bus.wqePop) begin
                if (fifo.size() == 0) check("pop_when_empty", 64'd1, 64'd0);
                else bus.wqeData = fifo.pop_front();
            end
            bus.wqeEmpty = (fifo.size() == 0);
        end
    end

    // AVMM slave stall generator
    initial begin
        bus.dcsWaitRequest = 1'b0;
        forever begin
            @(negedge clock);
            if (stallDirected) begin
                bus.dcsWaitRequest = bus.dcsChipSelect && (bus.dcsAddress == BASE + 8'h04) && (stallBudget > 0);
                if (bus.dcsWaitRequest) stallBudget--;
            end else if (randomStall) begin
                bus.dcsWaitRequest = ($urandom_range(3) == 0);
            end else begin
                bus.dcsWaitRequest = 1'b0;
            end
        end
    end

    // Monitor: compare every presented write and completion against the scoreboard
    initial begin
        wr_t w;
        ev_t e;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                if (bus.dcsChipSelect) begin
                    check("write_strobe", {bus.dcsWrite, bus.dcsByteEnable}, {1'b1, 4'hf});
                    if (expWr.size() == 0) begin
                        check("unexpected_write", {bus.dcsAddress, bus.dcsWriteData}, 64'd0);
                    end else begin
                        w = expWr[0];
                        check("wr_addr", bus.dcsAddress, w.addr);
                        check("wr_data", bus.dcsWriteData, w.data);
                        if (!bus.dcsWaitRequest) begin
                            void'(expWr.pop_front());
                            acceptCount++;
                        end else begin
                            stallCount++;
                        end
                    end
                end
                if (done || dropErr) begin
                    if (expEv.size() == 0) begin
                        check("unexpected_completion", {done, dropErr}, 2'b00);
                    end else begin
                        e = expEv.pop_front();
                        check("completion_kind", {done, dropErr}, {~e.drop, e.drop});
                        check("done_tid", doneTid, e.tid);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [8:0]  lens [4];
        logic [63:0] ta;
        int a0, s0, n;

        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_pop",   bus.wqePop, 1'b0);
        check("rst_cs",    {bus.dcsChipSelect, bus.dcsWrite}, 2'b00);
        check("rst_addr",  bus.dcsAddress, 8'd0);
        check("rst_data",  bus.dcsWriteData, 32'd0);
        check("rst_flags", {busy, done, dropErr}, 3'b000);
        check("rst_tid",   doneTid, 8'd0);
        #2 reset = 1'b1;
        enable = 1'b1;

        lens = '{9'd64, 9'd128, 9'd0, 9'd0};
        ta   = 64'h0000_0001_2345_6780;
        issue(5'h0A, 3'd2, 8'h5A, lens, ta);
        waitDrain(200);
        check("basic_tid", doneTid, 8'h5A);

        stallDirected = 1'b1;
        stallBudget   = 3;
        a0 = acceptCount;
        s0 = stallCount;
        issue(5'h0A, 3'd2, 8'h5A, lens, ta);
        waitDrain(200);
        check("stall_writes", 64'(acceptCount - a0), 64'd5);
        check("stall_cycles", 64'(stallCount - s0), 64'd3);
        stallDirected = 1'b0;

        a0 = acceptCount;
        issue(5'h03, 3'd0, 8'h11, lens, ta);
        waitDrain(200);
        check("drop_no_write", 64'(acceptCount - a0), 64'd0);
        check("drop_tid", doneTid, 8'h11);

        lens = '{9'd1, 9'd2, 9'd3, 9'd511};
        a0 = acceptCount;
        issue(5'h1F, 3'd7, 8'hC3, lens, 64'hFEDC_BA98_7654_3210);
        waitDrain(200);
        check("clamp_writes", 64'(acceptCount - a0), 64'd7);

        issue(5'h01, 3'd3, 8'h21, lens, 64'h1111_2222_3333_4444);
        issue(5'h02, 3'd1, 8'h22, lens, 64'h5555_6666_7777_8888);
        n = 0;
        while (!busy && n < 50) begin @(negedge clock); n++; end
        check("first_started", busy, 1'b1);
        enable = 1'b0;
        n = 0;
        while (expEv.size() > 1 && n < 100) begin @(negedge clock); n++; end
        repeat (10) @(negedge clock);
        check("second_held", 64'(fifo.size()), 64'd1);
        check("idle_while_disabled", busy, 1'b0);
        check("first_tid", doneTid, 8'h21);
        enable = 1'b1;
        waitDrain(200);
        check("second_tid", doneTid, 8'h22);

        issue(5'h05, 3'd4, 8'h77, lens, 64'hAAAA_BBBB_CCCC_DDDD);
        n = 0;
        while (!(bus.dcsChipSelect && bus.dcsAddress >= BASE + 8'h08 && bus.dcsAddress < BASE + 8'h18) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("reached_len", bus.dcsChipSelect, 1'b1);
        #3 reset = 1'b0;
        #1;
        check("midrst_pop_cs", {bus.wqePop, bus.dcsChipSelect, bus.dcsWrite}, 3'b000);
        check("midrst_addr", bus.dcsAddress, 8'd0);
        check("midrst_data", bus.dcsWriteData, 32'd0);
        check("midrst_flags", {busy, done, dropErr}, 3'b000);
        check("midrst_tid", doneTid, 8'd0);
        expWr.delete();
        expEv.delete();
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (5) @(negedge clock);
        check("post_rst_idle", {busy, bus.dcsChipSelect}, 2'b00);
        issue(5'h06, 3'd1, 8'h99, lens, 64'h0123_4567_89AB_CDEF);
        waitDrain(200);
        check("post_rst_tid", doneTid, 8'h99);

        randomStall = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 4; k++) lens[k] = 9'($urandom);
            ta = {$urandom, $urandom};
            issue(5'($urandom), 3'($urandom_range(7)), 8'($urandom), lens, ta);
            repeat ($urandom_range(6)) @(negedge clock);
            enable = ($urandom_range(4) != 0);
        end
        enable = 1'b1;
        waitDrain(5000);
        randomStall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wqe_dispatcher.md
WQE_DISPATCHER -- requirements
Module: wqe_dispatcher

Interface
REQ-001 Parameter DCS_BASE, default 8'h00, base offset added to every dcsAddress issued.
REQ-002 Parameter MAX_SEG, default 4, maximum number of length words issued per WQE.
REQ-003 clock  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  dispatch permitted when high (driven from credit/disable logic).
REQ-006 wqeEmpty  input  1  work FIFO empty flag.
REQ-007 wqePop  output  1  one-cycle FIFO pop strobe.
REQ-008 wqeData  input  116  popped WQE, valid the cycle after wqePop.
REQ-009 dcsChipSelect  output  1  AVMM master chipselect.
REQ-010 dcsWrite  output  1  AVMM write; equals dcsChipSelect.
REQ-011 dcsAddress  output  8  AVMM byte address.
REQ-012 dcsWriteData  output  32  AVMM write data.
REQ-013 dcsByteEnable  output  4  always 4'hf.
REQ-014 dcsWaitRequest  input  1  AVMM stall.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after the control word is accepted.
REQ-017 doneTid  output  8  TID of the last completed or dropped WQE, held until next update.
REQ-018 dropErr  output  1  one-cycle pulse when a WQE is discarded.

Function
REQ-019 WQE field map: opcode[115:111], dataNum[110:108], TID[107:100], dataLen0[99:91], dataLen1[90:82], dataLen2[81:73], dataLen3[72:64], tableAddr[63:0] = wqeData[63:0].
REQ-020 FSM states: IDLE, POP, LOAD, ADDR_LO, ADDR_HI, LEN, CTRL, DONE.
REQ-021 IDLE->POP when enable & ~wqeEmpty; wqePop is high for exactly the POP cycle.
REQ-022 POP->LOAD unconditionally; LOAD registers all WQE fields from wqeData.
REQ-023 In LOAD, a WQE with dataNum==0 is discarded: dropErr pulses, doneTid updates, FSM returns to IDLE, and no AVMM write is issued.
REQ-024 In LOAD, dataNum>MAX_SEG is clamped to MAX_SEG; FSM then enters ADDR_LO.
REQ-025 ADDR_LO writes tableAddr[31:0] to DCS_BASE+8'h00; ADDR_HI writes tableAddr[63:32] to DCS_BASE+8'h04.
REQ-026 LEN writes one word per segment k=0..dataNum-1 to DCS_BASE+8'h08+4k, with data {23'd0, dataLenk}; a 2-bit segment counter selects the word.
REQ-027 CTRL writes {opcode, dataNum, TID, 16'd0} to DCS_BASE+8'h18; this is the doorbell and is always the final write.
REQ-028 Each write holds address and data stable while dcsWaitRequest is high and advances only on a cycle where it is low.
REQ-029 DONE pulses done, updates doneTid, and returns to IDLE; the next pop can occur no earlier than the cycle after DONE.
REQ-030 Deasserting enable mid-WQE does not abort the WQE; enable is sampled only in IDLE.
REQ-031 Per-WQE write count = 3 + dataNum (after clamp); minimum write-phase latency with no stalls = 3 + dataNum cycles.

Reset
REQ-032 On reset assertion, the FSM enters IDLE asynchronously, and an AVMM write in progress is abandoned.
REQ-033 Reset values: wqePop=0, dcsChipSelect=0, dcsWrite=0, dcsAddress=0, dcsWriteData=0, busy=0, done=0, dropErr=0, doneTid=0; all counters are 0.

Configuration
REQ-034 WQE_DISPATCH_STATS_EN defined: adds outputs statDispatched[15:0] and statDropped[15:0]; each increments on done or dropErr respectively and wraps at 16'hffff to 0.
REQ-035 WQE_DISPATCH_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-036 Package wqe_pkg holds the WQE field bit positions, the DCS register offsets (0x00/0x04/0x08/0x18), the FSM state encoding and the 116-bit WQE width constant.
REQ-037 The block is a single module with no sub-modules.

Verification
REQ-038 wqeData TID=8'h5A, dataNum=2, lens 9'd64/9'd128, tableAddr=64'h0000_0001_2345_6780, no stall -> writes 0x00=23456780, 0x04=00000001, 0x08=00000040, 0x0C=00000080, 0x18={opcode,3'd2,8'h5A,16'd0}; done pulses with doneTid=5A.
REQ-039 Same WQE with dcsWaitRequest high for 3 cycles on the 0x04 write -> address and data held for those 3 cycles, sequence unchanged, exactly 5 writes issued.
REQ-040 dataNum=0, TID=8'h11 -> no chipselect, dropErr pulses once, doneTid=11.
REQ-041 dataNum=7 -> exactly 4 length writes (0x08..0x14), CTRL carries dataNum=4.
REQ-042 Two WQEs queued, enable dropped during the first -> first completes, second is not popped until enable returns high.
REQ-043 Reset asserted during the LEN state -> all outputs go to 0 immediately; after release the FSM idles until ~wqeEmpty & enable.
